dmem_align_unit: RTL and testbench
==================================

Name: dmem_align_unit

Overview:
Sits between the memory stage's data request/response port (DRequest/DResponse) and the word-aligned data memory bus. Converts byte-addressed, variable-size requests into word-aligned bus beats with per-byte strobes. Splits accesses that cross a word boundary into two beats and merges or realigns load data so that the byte at the request address returns in rdata[7:0]. One request is outstanding at a time; ordering is strictly preserved.

Parameters:
ADDR_W, 32, address width; word address is {addr[ADDR_W-1:2], 2'b00}.
SPLIT_EN, 1, enables the second beat for boundary-crossing accesses. When 0, only the first beat is issued and misalign_err pulses.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
up_valid  in  1  request valid; held by the requester until up_ready
up_ready  out  1  request accepted this cycle when up_valid && up_ready
up_wen  in  1  1 = store, 0 = load
up_addr  in  ADDR_W  byte address
up_wdata  in  32  store data, LSB-aligned
up_wmask  in  32  size: 0x000000ff = byte, 0x0000ffff = half, any other value = word
up_kill  in  1  drop the pending load response
up_rvalid  out  1  load data valid, one-cycle pulse
up_rdata  out  32  4 bytes starting at the latched addr, LSB = byte at addr
mem_valid  out  1  bus beat valid
mem_ready  in  1  bus accepts the beat
mem_wen  out  1  beat is a write
mem_addr  out  ADDR_W  word-aligned beat address
mem_wdata  out  32  lane-aligned write data; unselected lanes driven 0
mem_wstrb  out  4  byte strobes; 4'hf for reads
mem_rvalid  in  1  read beat data valid
mem_rdata  in  32  read beat data
misalign_err  out  1  one-cycle pulse when SPLIT_EN=0 truncates an access

Behaviour:
- Reset values: state=IDLE; up_ready=1; up_rvalid=0; mem_valid=0; mem_wen=0; mem_addr=0; mem_wstrb=0; mem_wdata=0; misalign_err=0; kill flag=0. Reset mid-operation abandons the transaction immediately: mem_valid falls asynchronously and no up_rvalid is produced.
- Handshake and latching:
  - up_ready = (state==IDLE).
  - On accept, latch wen, addr, wdata and size. Compute o = addr[1:0].
  - Byte mask: bm = 1, 3 or 15 for byte/half/word.
  - Store: s8 = bm<<o (8 bits); d64 = wdata<<(8*o).
  - Load: s8 = 8'h0f<<o.
  - Beat0: addr {a[31:2],00}, strobe s8[3:0], data d64[31:0].
  - Beat1 is needed iff s8[7:4] != 0. Beat1: addr = beat0 addr + 4, wrapping to 0 at the top; strobe s8[7:4]; data d64[63:32].
- FSM states: IDLE, REQ0, RSP0, REQ1, RSP1.
  - IDLE -> REQ0 on accept. mem_valid rises the cycle after accept, with registered outputs.
  - REQx: hold mem_valid and payload stable until mem_ready.
    - Write, no further beat -> IDLE.
    - Write, beat1 needed and SPLIT_EN -> REQ1.
    - Read -> RSPx.
  - RSP0: on mem_rvalid, save rdata to buf0.
    - If beat1 is needed and SPLIT_EN, go to REQ1.
    - Otherwise complete and go to IDLE.
  - RSP1: on mem_rvalid, complete and go to IDLE.
- Load completion: up_rvalid is asserted combinationally in the same cycle as the final mem_rvalid.
  - up_rdata = ({r1, r0} >> 8*o)[31:0], where r0 = buf0 (or mem_rdata if beat0 is final) and r1 = mem_rdata.
  - When truncated, r1 = 0.
- Truncation: when SPLIT_EN=0 and beat1 would be needed, misalign_err pulses in the completion cycle. For stores, that is the cycle of mem_ready.
- Latency with a zero-wait bus (ready same cycle, rvalid next cycle):
  - Aligned load: up_rvalid at accept+2.
  - Split load: up_rvalid at accept+4.
  - Aligned store: returns to IDLE at accept+2.
- Kill:
  - up_kill in any non-IDLE load state sets the kill flag.
  - Outstanding beats still complete: mem_valid is held until mem_ready, and mem_rvalid is absorbed.
  - up_rvalid is suppressed; the flag clears on return to IDLE.
  - up_kill on the accept cycle also applies.
  - Kill does not affect stores: an accepted store always completes all beats.
- mem_rvalid outside RSPx is ignored and is an assertion failure. mem_ready outside REQx is ignored.

Decomposition:
- Package dmem_align_pkg holds:
  - the state enum;
  - size encoding (SZ_B, SZ_H, SZ_W);
  - function size_from_wmask;
  - function byte_mask(size).
- Sub-module dmem_lane_shifter (purely combinational) handles store strobe/data alignment and load merge/shift. It is instantiated once.

Test Plan:
- Aligned word load, addr 0x100, mem_rdata 0xdeadbeef -> one read beat at 0x100 with strobe f; up_rvalid at accept+2 with 0xdeadbeef.
- Byte store, addr 0x203, wdata 0x000000a5, wmask 0xff -> single beat: addr 0x200, strobe 4'b1000, wdata 0xa5000000.
- Half store, addr 0x103, wdata 0x1234 -> two beats:
  - beat0 at 0x100, strobe 1000, data 0x34000000;
  - beat1 at 0x104, strobe 0001, data 0x00000012.
- Split load, addr 0x102, word0 0x44332211, word1 0x88776655 -> beats at 0x100 and 0x104; up_rdata 0x66554433.
- up_kill during RSP0 of an aligned load with mem_rvalid delayed 3 cycles -> no up_rvalid; up_ready returns after mem_rvalid.
- SPLIT_EN=0, word load at 0xFFFFFFFE -> single beat at 0xFFFFFFFC; misalign_err pulses with up_rvalid; up_rdata[31:16]=0. Separately, with SPLIT_EN=1: beat1 addr wraps to 0x00000000. Then assert rst_n low during REQ1 -> mem_valid drops immediately and up_ready=1 after release.

Source files
------------

// File: rtl/dmem_align_pkg.sv
// Shared types and helpers for the data-memory alignment unit.
package dmem_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ0 = 3'd1,
    ST_RSP0 = 3'd2,
    ST_REQ1 = 3'd3,
    ST_RSP1 = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Requester encodes access size as a lane mask; anything unusual is a word.
  function automatic size_t size_from_wmask(input logic [31:0] wmask);
    size_t sz;
    if (wmask == 32'h0000_00ff) begin
      sz = SZ_B;
    end else if (wmask == 32'h0000_ffff) begin
      sz = SZ_H;
    end else begin
      sz = SZ_W;
    end
    return sz;
  endfunction

  // Byte-enable pattern of an LSB-aligned access of the given size.
  function automatic logic [3:0] byte_mask(input size_t sz);
    logic [3:0] bm;
    case (sz)
      SZ_B:    bm = 4'b0001;
      SZ_H:    bm = 4'b0011;
      default: bm = 4'b1111;
    endcase
    return bm;
  endfunction

endpackage

// File: rtl/dmem_lane_shifter.sv
// Combinational lane logic: store strobe/data placement over two words and
// load realignment of a two-word window down to the request byte.
module dmem_lane_shifter
  import dmem_align_pkg::*;
(
  input  logic        wen,
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic [31:0] wdata,
  input  logic [31:0] r0,
  input  logic [31:0] r1,
  output logic [3:0]  strb0,
  output logic [3:0]  strb1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic        need_beat1,
  output logic [31:0] rdata
);

  logic [3:0]  bm;
  logic [7:0]  s8;
  logic [31:0] wdata_m;
  logic [63:0] d64;
  logic [63:0] merged;

  // Place strobes/data across the two-word window and shift load data down.
  always_comb begin
    bm = byte_mask(size);
    if (wen) begin
      s8 = {4'b0000, bm} << off;
    end else begin
      s8 = 8'h0f << off;
    end
    // Lanes outside the access size are zeroed so unselected lanes stay 0.
    wdata_m    = wdata & {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
    d64        = {32'h0000_0000, wdata_m} << {off, 3'b000};
    merged     = {r1, r0} >> {off, 3'b000};
    strb0      = s8[3:0];
    strb1      = s8[7:4];
    wdata0     = d64[31:0];
    wdata1     = d64[63:32];
    need_beat1 = (s8[7:4] != 4'b0000);
    rdata      = merged[31:0];
  end

endmodule

// File: rtl/dmem_align_unit.sv
// Converts byte-addressed variable-size requests into word-aligned bus beats,
// splitting boundary-crossing accesses and realigning load data.
module dmem_align_unit
  import dmem_align_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic              up_wen,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [31:0]       up_wdata,
  input  logic [31:0]       up_wmask,
  input  logic              up_kill,
  output logic              up_rvalid,
  output logic [31:0]       up_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              misalign_err
);

  state_t            state;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  size_t             req_size;
  logic              kill;
  logic [31:0]       buf0;

  logic              sh_wen;
  logic [1:0]        sh_off;
  size_t             sh_size;
  logic [31:0]       sh_wdata;
  logic [31:0]       sh_r0;
  logic [31:0]       sh_r1;
  logic [3:0]        strb0;
  logic [3:0]        strb1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              need_beat1;
  logic              do_beat1;
  logic              load_done;

  // While idle the shifter looks at the incoming request so beat0 can be
  // registered on accept; afterwards it works on the latched request.
  always_comb begin
    if (state == ST_IDLE) begin
      sh_wen   = up_wen;
      sh_off   = up_addr[1:0];
      sh_size  = size_from_wmask(up_wmask);
      sh_wdata = up_wdata;
    end else begin
      sh_wen   = req_wen;
      sh_off   = req_addr[1:0];
      sh_size  = req_size;
      sh_wdata = req_wdata;
    end
  end

  // Load window: in RSP1 buf0 holds the low word; otherwise the beat is final
  // on its own and the upper word reads as zero (aligned or truncated).
  always_comb begin
    if (state == ST_RSP1) begin
      sh_r0 = buf0;
      sh_r1 = mem_rdata;
    end else begin
      sh_r0 = mem_rdata;
      sh_r1 = 32'h0000_0000;
    end
  end

  dmem_lane_shifter u_shifter (
    .wen        (sh_wen),
    .off        (sh_off),
    .size       (sh_size),
    .wdata      (sh_wdata),
    .r0         (sh_r0),
    .r1         (sh_r1),
    .strb0      (strb0),
    .strb1      (strb1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .need_beat1 (need_beat1),
    .rdata      (up_rdata)
  );

  assign do_beat1  = need_beat1 && SPLIT_EN;
  assign up_ready  = (state == ST_IDLE);
  assign load_done = !req_wen && mem_rvalid &&
                     (((state == ST_RSP0) && !do_beat1) || (state == ST_RSP1));
  // A kill raised in the completion cycle itself still drops the response.
  assign up_rvalid = load_done && !kill && !up_kill;
  assign misalign_err = need_beat1 && !SPLIT_EN &&
                        (((state == ST_REQ0) && req_wen && mem_ready) ||
                         ((state == ST_RSP0) && !req_wen && mem_rvalid));

  // Transaction FSM with registered bus payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_wen   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= 32'h0000_0000;
      req_size  <= SZ_W;
      kill      <= 1'b0;
      buf0      <= 32'h0000_0000;
      mem_valid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0000_0000;
    end else begin
      if ((state != ST_IDLE) && !req_wen && up_kill) begin
        kill <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (up_valid) begin
            req_wen   <= up_wen;
            req_addr  <= up_addr;
            req_wdata <= up_wdata;
            req_size  <= sh_size;
            kill      <= up_kill && !up_wen;
            mem_valid <= 1'b1;
            mem_wen   <= up_wen;
            mem_addr  <= {up_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb <= up_wen ? strb0 : 4'hf;
            mem_wdata <= up_wen ? wdata0 : 32'h0000_0000;
            state     <= ST_REQ0;
          end
        end
        ST_REQ0: begin
          if (mem_ready) begin
            if (req_wen && do_beat1) begin
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
              mem_wstrb <= strb1;
              mem_wdata <= wdata1;
              state     <= ST_REQ1;
            end else if (req_wen) begin
              mem_valid <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              mem_valid <= 1'b0;
              state     <= ST_RSP0;
            end
          end
        end
        ST_RSP0: begin
          if (mem_rvalid) begin
            buf0 <= mem_rdata;
            if (do_beat1) begin
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
              mem_wstrb <= 4'hf;
              mem_wdata <= 32'h0000_0000;
              state     <= ST_REQ1;
            end else begin
              kill  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        ST_REQ1: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= req_wen ? ST_IDLE : ST_RSP1;
          end
        end
        ST_RSP1: begin
          if (mem_rvalid) begin
            kill  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          mem_valid <= 1'b0;
          kill      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_align_unit.sv
// Directed bench: one split-enabled and one split-disabled instance share the
// request/bus stimulus; sel chooses which instance is being exercised.
module tb_dmem_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        up_valid, up_wen, up_kill, mem_ready, mem_rvalid;
  logic [31:0] up_addr, up_wdata, up_wmask, mem_rdata;

  logic        a_up_valid, a_mem_ready, a_mem_rvalid;
  logic        b_up_valid, b_mem_ready, b_mem_rvalid;
  logic        a_up_ready, a_up_rvalid, a_mem_valid, a_mem_wen, a_misalign_err;
  logic        b_up_ready, b_up_rvalid, b_mem_valid, b_mem_wen, b_misalign_err;
  logic [31:0] a_up_rdata, a_mem_addr, a_mem_wdata;
  logic [31:0] b_up_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  a_mem_wstrb, b_mem_wstrb;

  logic        o_up_ready, o_up_rvalid, o_mem_valid, o_mem_wen, o_misalign_err;
  logic [31:0] o_up_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign a_up_valid   = up_valid   & ~sel;
  assign b_up_valid   = up_valid   &  sel;
  assign a_mem_ready  = mem_ready  & ~sel;
  assign b_mem_ready  = mem_ready  &  sel;
  assign a_mem_rvalid = mem_rvalid & ~sel;
  assign b_mem_rvalid = mem_rvalid &  sel;

  assign o_up_ready     = sel ? b_up_ready     : a_up_ready;
  assign o_up_rvalid    = sel ? b_up_rvalid    : a_up_rvalid;
  assign o_up_rdata     = sel ? b_up_rdata     : a_up_rdata;
  assign o_mem_valid    = sel ? b_mem_valid    : a_mem_valid;
  assign o_mem_wen      = sel ? b_mem_wen      : a_mem_wen;
  assign o_mem_addr     = sel ? b_mem_addr     : a_mem_addr;
  assign o_mem_wdata    = sel ? b_mem_wdata    : a_mem_wdata;
  assign o_mem_wstrb    = sel ? b_mem_wstrb    : a_mem_wstrb;
  assign o_misalign_err = sel ? b_misalign_err : a_misalign_err;

  dmem_align_unit #(.ADDR_W(32), .SPLIT_EN(1'b1)) u_dut_split (
    .clk(clk), .rst_n(rst_n),
    .up_valid(a_up_valid), .up_ready(a_up_ready), .up_wen(up_wen),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_wmask(up_wmask),
    .up_kill(up_kill), .up_rvalid(a_up_rvalid), .up_rdata(a_up_rdata),
    .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_wen(a_mem_wen),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(mem_rdata),
    .misalign_err(a_misalign_err)
  );

  dmem_align_unit #(.ADDR_W(32), .SPLIT_EN(1'b0)) u_dut_nosplit (
    .clk(clk), .rst_n(rst_n),
    .up_valid(b_up_valid), .up_ready(b_up_ready), .up_wen(up_wen),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_wmask(up_wmask),
    .up_kill(up_kill), .up_rvalid(b_up_rvalid), .up_rdata(b_up_rdata),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(mem_rdata),
    .misalign_err(b_misalign_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle (caller is already past the edge).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] m);
    up_valid = 1'b1;
    up_wen   = w;
    up_addr  = a;
    up_wdata = d;
    up_wmask = m;
    #1;
    check("accept_ready", o_up_ready, 1'b1);
    cyc();
    up_valid = 1'b0;
  endtask

  initial begin
    sel = 1'b0; up_valid = 1'b0; up_wen = 1'b0; up_addr = 32'h0; up_wdata = 32'h0;
    up_wmask = 32'h0; up_kill = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_up_ready", o_up_ready, 1'b1);
    check("rst_up_rvalid", o_up_rvalid, 1'b0);
    check("rst_mem_valid", o_mem_valid, 1'b0);
    check("rst_mem_wen", o_mem_wen, 1'b0);
    check("rst_mem_addr", o_mem_addr, 32'h0);
    check("rst_mem_wstrb", o_mem_wstrb, 4'h0);
    check("rst_mem_wdata", o_mem_wdata, 32'h0);
    check("rst_misalign", o_misalign_err, 1'b0);
    rst_n = 1'b1;

    // Aligned word load at 0x100.
    cyc();
    issue(1'b0, 32'h0000_0100, 32'h0, 32'hffff_ffff);
    mem_ready = 1'b1; #1;
    check("ld_a_valid", o_mem_valid, 1'b1);
    check("ld_a_wen", o_mem_wen, 1'b0);
    check("ld_a_addr", o_mem_addr, 32'h0000_0100);
    check("ld_a_strb", o_mem_wstrb, 4'hf);
    check("ld_a_rvalid_early", o_up_rvalid, 1'b0);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hdead_beef; #1;
    check("ld_a_rvalid", o_up_rvalid, 1'b1);
    check("ld_a_rdata", o_up_rdata, 32'hdead_beef);
    cyc(); mem_rvalid = 1'b0; #1;
    check("ld_a_idle", o_up_ready, 1'b1);
    check("ld_a_rvalid_off", o_up_rvalid, 1'b0);

    // Byte store at 0x203.
    cyc();
    issue(1'b1, 32'h0000_0203, 32'h0000_00a5, 32'h0000_00ff);
    mem_ready = 1'b1; #1;
    check("st_b_valid", o_mem_valid, 1'b1);
    check("st_b_wen", o_mem_wen, 1'b1);
    check("st_b_addr", o_mem_addr, 32'h0000_0200);
    check("st_b_strb", o_mem_wstrb, 4'b1000);
    check("st_b_wdata", o_mem_wdata, 32'ha500_0000);
    cyc(); mem_ready = 1'b0; #1;
    check("st_b_idle", o_up_ready, 1'b1);
    check("st_b_valid_off", o_mem_valid, 1'b0);

    // Half store at 0x103 crossing a word: two beats, beat0 stalled a cycle.
    cyc();
    issue(1'b1, 32'h0000_0103, 32'h0000_1234, 32'h0000_ffff);
    #1;
    check("st_h0_valid", o_mem_valid, 1'b1);
    cyc(); mem_ready = 1'b1; #1;
    check("st_h0_addr", o_mem_addr, 32'h0000_0100);
    check("st_h0_strb", o_mem_wstrb, 4'b1000);
    check("st_h0_wdata", o_mem_wdata, 32'h3400_0000);
    cyc(); #1;
    check("st_h1_valid", o_mem_valid, 1'b1);
    check("st_h1_addr", o_mem_addr, 32'h0000_0104);
    check("st_h1_strb", o_mem_wstrb, 4'b0001);
    check("st_h1_wdata", o_mem_wdata, 32'h0000_0012);
    cyc(); mem_ready = 1'b0; #1;
    check("st_h_idle", o_up_ready, 1'b1);

    // Split load at 0x102.
    cyc();
    issue(1'b0, 32'h0000_0102, 32'h0, 32'hffff_ffff);
    mem_ready = 1'b1; #1;
    check("ld_s0_addr", o_mem_addr, 32'h0000_0100);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4433_2211; #1;
    check("ld_s0_rvalid", o_up_rvalid, 1'b0);
    cyc(); mem_rvalid = 1'b0; mem_ready = 1'b1; #1;
    check("ld_s1_valid", o_mem_valid, 1'b1);
    check("ld_s1_addr", o_mem_addr, 32'h0000_0104);
    check("ld_s1_strb", o_mem_wstrb, 4'hf);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655; #1;
    check("ld_s_rvalid", o_up_rvalid, 1'b1);
    check("ld_s_rdata", o_up_rdata, 32'h6655_4433);
    check("ld_s_misalign", o_misalign_err, 1'b0);
    cyc(); mem_rvalid = 1'b0; #1;
    check("ld_s_idle", o_up_ready, 1'b1);

    // Kill during RSP0 of an aligned load; rvalid three cycles late.
    cyc();
    issue(1'b0, 32'h0000_0100, 32'h0, 32'hffff_ffff);
    mem_ready = 1'b1;
    cyc(); mem_ready = 1'b0; up_kill = 1'b1;
    cyc(); up_kill = 1'b0;
    cyc();
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; #1;
    check("kill_rvalid", o_up_rvalid, 1'b0);
    check("kill_busy", o_up_ready, 1'b0);
    cyc(); mem_rvalid = 1'b0; #1;
    check("kill_idle", o_up_ready, 1'b1);
    check("kill_rvalid_after", o_up_rvalid, 1'b0);

    // No-split instance: word load at 0xFFFFFFFE is truncated.
    sel = 1'b1;
    cyc();
    issue(1'b0, 32'hffff_fffe, 32'h0, 32'hffff_ffff);
    mem_ready = 1'b1; #1;
    check("tr_ld_addr", o_mem_addr, 32'hffff_fffc);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'haabb_ccdd; #1;
    check("tr_ld_rvalid", o_up_rvalid, 1'b1);
    check("tr_ld_misalign", o_misalign_err, 1'b1);
    check("tr_ld_rdata", o_up_rdata, 32'h0000_aabb);
    cyc(); mem_rvalid = 1'b0; #1;
    check("tr_ld_misalign_off", o_misalign_err, 1'b0);
    check("tr_ld_idle", o_up_ready, 1'b1);
    check("tr_ld_valid_off", o_mem_valid, 1'b0);

    // No-split instance: crossing half store pulses misalign_err on mem_ready.
    cyc();
    issue(1'b1, 32'h0000_0103, 32'h0000_1234, 32'h0000_ffff);
    mem_ready = 1'b1; #1;
    check("tr_st_misalign", o_misalign_err, 1'b1);
    check("tr_st_strb", o_mem_wstrb, 4'b1000);
    cyc(); mem_ready = 1'b0; #1;
    check("tr_st_idle", o_up_ready, 1'b1);
    check("tr_st_valid_off", o_mem_valid, 1'b0);

    // Split instance: beat1 address wraps to 0, then reset during REQ1.
    sel = 1'b0;
    cyc();
    issue(1'b0, 32'hffff_fffe, 32'h0, 32'hffff_ffff);
    mem_ready = 1'b1; #1;
    check("wr_b0_addr", o_mem_addr, 32'hffff_fffc);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0102_0304;
    cyc(); mem_rvalid = 1'b0; #1;
    check("wr_b1_valid", o_mem_valid, 1'b1);
    check("wr_b1_addr", o_mem_addr, 32'h0000_0000);
    rst_n = 1'b0; #1;
    check("rst_mid_valid", o_mem_valid, 1'b0);
    cyc(); rst_n = 1'b1; #1;
    check("rst_mid_ready", o_up_ready, 1'b1);
    check("rst_mid_rvalid", o_up_rvalid, 1'b0);
    cyc(); #1;
    check("rst_mid_valid_after", o_mem_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
